// File: rtl/data_path_sequencer.sv
// Command sequencer for data_path: loads K weight rows from BRAM, commits them,
// meters ifmap pops from the FIFO and waits for every psum to return.
module data_path_sequencer #(
    parameter int MAC_NUM = 256,
    parameter int TIMEOUT = 1023
) (
    input  logic               clk,
    input  logic               rst_n,
    // Handshake: a command transfers on a rising edge where cmd_valid and
    // cmd_ready are both 1; cmd_ready is 1 only in IDLE, and the fields must
    // be stable while cmd_valid is 1.
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [31:0]        cmd_opcode,
    input  logic [4:0]         cmd_kernel_size,
    input  logic [11:0]        cmd_channels,
    input  logic [15:0]        cmd_pixels,
    input  logic [1:0]         cmd_operation,
    input  logic [MAC_NUM-1:0] cmd_mac_mask,
    output logic [MAC_NUM-1:0] MAC_enable,
    output logic [1:0]         operation,
    output logic [4:0]         kernel_size,
    output logic [11:0]        input_channel_size,
    output logic               address_reset,
    output logic               bram_control_add1,
    output logic               bram_control_add2,
    output logic               port_sel,
    output logic               load_weight_preload,
    output logic               load_weight,
    output logic               load_ifmaps,
    input  logic               weight_from_bram_valid,
    input  logic               ifmaps_fifo_empty,
    input  logic               psum_valid,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [15:0]        psum_count,
    output logic [3:0]         o_dbg_state
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_RST_ADDR = 4'd1,
        ST_W_REQ    = 4'd2,
        ST_W_WAIT   = 4'd3,
        ST_W_LATCH  = 4'd4,
        ST_W_COMMIT = 4'd5,
        ST_COMPUTE  = 4'd6,
        ST_DRAIN    = 4'd7,
        ST_FINISH   = 4'd8
    } state_t;

    state_t               r_state;
    logic [2:0]           r_row;
    logic [15:0]          r_remaining;
    logic [15:0]          r_pixels;
    logic [15:0]          r_psum_count;
    logic [TW-1:0]        r_timer;
    logic                 r_err;
    logic [MAC_NUM-1:0]   r_mac_enable;
    logic [1:0]           r_operation;
    logic [4:0]           r_kernel_size;
    logic [11:0]          r_channels;

    logic w_cmd_legal;
    logic w_pop;
    logic w_last_row;
    logic w_psum_inc;

    assign w_cmd_legal = ((cmd_opcode == 32'd87) || (cmd_opcode == 32'd88)) &&
                         (cmd_kernel_size != 5'd0) && (cmd_kernel_size <= 5'd5);
    assign w_pop       = (r_state == ST_COMPUTE) && !ifmaps_fifo_empty && (r_remaining != 16'd0);
    assign w_last_row  = ({2'b00, r_row} == (r_kernel_size - 5'd1));
    assign w_psum_inc  = psum_valid && ((r_state == ST_COMPUTE) || (r_state == ST_DRAIN)) &&
                         (r_psum_count != 16'hFFFF);

    // The wait timer defaults to clear each cycle; only a state that keeps waiting advances it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_row         <= 3'd0;
            r_remaining   <= 16'd0;
            r_pixels      <= 16'd0;
            r_psum_count  <= 16'd0;
            r_timer       <= '0;
            r_err         <= 1'b0;
            r_mac_enable  <= '0;
            r_operation   <= 2'd0;
            r_kernel_size <= 5'd0;
            r_channels    <= 12'd0;
        end else begin
            r_err   <= 1'b0;
            r_timer <= '0;
            if (w_pop) begin
                r_remaining <= r_remaining - 16'd1;
            end
            if (w_psum_inc) begin
                r_psum_count <= r_psum_count + 16'd1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        if (w_cmd_legal) begin
                            r_mac_enable  <= cmd_mac_mask;
                            r_operation   <= cmd_operation;
                            r_kernel_size <= cmd_kernel_size;
                            r_channels    <= cmd_channels;
                            r_pixels      <= cmd_pixels;
                            r_remaining   <= cmd_pixels;
                            r_psum_count  <= 16'd0;
                            r_state       <= (cmd_opcode == 32'd87) ? ST_RST_ADDR : ST_COMPUTE;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                ST_RST_ADDR: begin
                    r_row   <= 3'd0;
                    r_state <= ST_W_REQ;
                end
                ST_W_REQ: begin
                    r_state <= ST_W_WAIT;
                end
                ST_W_WAIT: begin
                    if (weight_from_bram_valid) begin
                        r_state <= ST_W_LATCH;
                    end else if (r_timer == TMAX) begin
                        r_state <= ST_IDLE;
                        r_err   <= 1'b1;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                ST_W_LATCH: begin
                    if (w_last_row) begin
                        r_state <= ST_W_COMMIT;
                    end else begin
                        r_row   <= r_row + 3'd1;
                        r_state <= ST_W_REQ;
                    end
                end
                ST_W_COMMIT: begin
                    r_state <= ST_COMPUTE;
                end
                ST_COMPUTE: begin
                    // Leave as soon as the final pop is issued, or at once when nothing is owed.
                    if ((r_remaining == 16'd0) || (w_pop && (r_remaining == 16'd1))) begin
                        r_state <= ST_DRAIN;
                    end else if (ifmaps_fifo_empty) begin
                        if (r_timer == TMAX) begin
                            r_state <= ST_IDLE;
                            r_err   <= 1'b1;
                        end else begin
                            r_timer <= r_timer + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (r_psum_count == r_pixels) begin
                        r_state <= ST_FINISH;
                    end else if (r_timer == TMAX) begin
                        r_state <= ST_IDLE;
                        r_err   <= 1'b1;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                ST_FINISH: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready           = (r_state == ST_IDLE);
    assign busy                = (r_state != ST_IDLE);
    assign done                = (r_state == ST_FINISH);
    assign err                 = r_err;
    assign address_reset       = (r_state == ST_RST_ADDR);
    assign bram_control_add1   = (r_state == ST_W_REQ);
    assign bram_control_add2   = 1'b0;
    assign load_weight_preload = (r_state == ST_W_LATCH);
    assign load_weight         = (r_state == ST_W_COMMIT);
    assign port_sel            = ((r_state == ST_W_REQ) || (r_state == ST_W_WAIT) ||
                                  (r_state == ST_W_LATCH)) ? r_row[0] : 1'b0;
    assign load_ifmaps         = w_pop;
    assign psum_count          = r_psum_count;
    assign MAC_enable          = r_mac_enable;
    assign operation           = r_operation;
    assign kernel_size         = r_kernel_size;
    assign input_channel_size  = r_channels;
    assign o_dbg_state         = r_state;

endmodule

// File: tb/tb_data_path_sequencer.sv
// Bench for data_path_sequencer: BRAM/FIFO/psum responders, an event monitor,
// and expected event cycles derived from the command and environment settings.
module tb_data_path_sequencer;

  localparam int MAC_NUM = 256;
  localparam int TIMEOUT = 1023;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               cmd_valid;
  logic               cmd_ready;
  logic [31:0]        cmd_opcode;
  logic [4:0]         cmd_kernel_size;
  logic [11:0]        cmd_channels;
  logic [15:0]        cmd_pixels;
  logic [1:0]         cmd_operation;
  logic [MAC_NUM-1:0] cmd_mac_mask;
  logic [MAC_NUM-1:0] MAC_enable;
  logic [1:0]         operation;
  logic [4:0]         kernel_size;
  logic [11:0]        input_channel_size;
  logic               address_reset, bram_control_add1, bram_control_add2, port_sel;
  logic               load_weight_preload, load_weight, load_ifmaps;
  logic               weight_from_bram_valid, ifmaps_fifo_empty, psum_valid;
  logic               busy, done, err;
  logic [15:0]        psum_count;
  logic [3:0]         dbg_state;

  data_path_sequencer #(.MAC_NUM(MAC_NUM), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opcode(cmd_opcode), .cmd_kernel_size(cmd_kernel_size), .cmd_channels(cmd_channels),
    .cmd_pixels(cmd_pixels), .cmd_operation(cmd_operation), .cmd_mac_mask(cmd_mac_mask),
    .MAC_enable(MAC_enable), .operation(operation), .kernel_size(kernel_size),
    .input_channel_size(input_channel_size), .address_reset(address_reset),
    .bram_control_add1(bram_control_add1), .bram_control_add2(bram_control_add2),
    .port_sel(port_sel), .load_weight_preload(load_weight_preload), .load_weight(load_weight),
    .load_ifmaps(load_ifmaps), .weight_from_bram_valid(weight_from_bram_valid),
    .ifmaps_fifo_empty(ifmaps_fifo_empty), .psum_valid(psum_valid), .busy(busy), .done(done),
    .err(err), .psum_count(psum_count), .o_dbg_state(dbg_state)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- environment configuration ----------------
  int bram_lat = 1;
  int psum_dly = 1;
  int fifo_mode = 0;  // 0 never empty, 1 empty on odd cycles, 2 random, 3 always empty
  bit bram_en = 1'b1;
  bit emp_hist[int];

  int acc_q[$], ar_q[$], add1_q[$], add1_ps_q[$], pre_q[$], pre_ps_q[$];
  int lw_q[$], pop_q[$], done_q[$], err_q[$], bram_q[$], psum_sched_q[$];
  logic [31:0] exp_q[$];
  int pop_empty, busy_cnt, add2_cnt;

  int n_pass = 0, n_fail = 0, n_total = 0;

  logic [MAC_NUM-1:0] last_mask;
  logic [1:0]         last_op;
  logic [4:0]         last_k;
  logic [11:0]        last_ch;
  int                 last_psum;

  // Responders drive their inputs 1 time unit after the rising edge.
  always @(posedge clk) begin
    #1;
    weight_from_bram_valid = 1'b0;
    while (bram_q.size() > 0 && bram_q[0] < cyc) void'(bram_q.pop_front());
    if (bram_q.size() > 0 && bram_q[0] == cyc) begin
      weight_from_bram_valid = 1'b1;
      void'(bram_q.pop_front());
    end
    psum_valid = 1'b0;
    while (psum_sched_q.size() > 0 && psum_sched_q[0] < cyc) void'(psum_sched_q.pop_front());
    if (psum_sched_q.size() > 0 && psum_sched_q[0] == cyc) begin
      psum_valid = 1'b1;
      void'(psum_sched_q.pop_front());
    end
    case (fifo_mode)
      0: ifmaps_fifo_empty = 1'b0;
      1: ifmaps_fifo_empty = cyc[0];
      2: ifmaps_fifo_empty = ($urandom_range(0, 3) == 0);
      default: ifmaps_fifo_empty = 1'b1;
    endcase
    emp_hist[cyc] = ifmaps_fifo_empty;
  end

  // Monitor: records the cycle of every strobe, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (cmd_valid && cmd_ready) acc_q.push_back(cyc);
      if (address_reset) ar_q.push_back(cyc);
      if (bram_control_add1) begin
        add1_q.push_back(cyc);
        add1_ps_q.push_back(int'(port_sel));
        if (bram_en) bram_q.push_back(cyc + bram_lat);
      end
      if (load_weight_preload) begin
        pre_q.push_back(cyc);
        pre_ps_q.push_back(int'(port_sel));
      end
      if (load_weight) lw_q.push_back(cyc);
      if (load_ifmaps) begin
        pop_q.push_back(cyc);
        if (ifmaps_fifo_empty) pop_empty++;
        psum_sched_q.push_back(cyc + psum_dly);
      end
      if (done) done_q.push_back(cyc);
      if (err) err_q.push_back(cyc);
      if (busy) busy_cnt++;
      if (bram_control_add2) add2_cnt++;
    end
  end

  // ---------------- driver / check tasks ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_mask(input string tag, input logic [MAC_NUM-1:0] obs, input logic [MAC_NUM-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  function automatic logic [MAC_NUM-1:0] rand_mask();
    logic [MAC_NUM-1:0] m;
    for (int i = 0; i < MAC_NUM / 32; i++) m[i*32 +: 32] = $urandom();
    return m;
  endfunction

  task automatic clear_rec();
    acc_q.delete(); ar_q.delete(); add1_q.delete(); add1_ps_q.delete();
    pre_q.delete(); pre_ps_q.delete(); lw_q.delete(); pop_q.delete();
    done_q.delete(); err_q.delete(); bram_q.delete(); psum_sched_q.delete();
    exp_q.delete();
    pop_empty = 0;
    busy_cnt = 0;
  endtask

  task automatic drive_cmd(input logic [31:0] op, input int k, input int pix, input logic [1:0] opn,
                           input logic [11:0] ch, input logic [MAC_NUM-1:0] mask);
    cmd_opcode      = op;
    cmd_kernel_size = 5'(k);
    cmd_pixels      = 16'(pix);
    cmd_operation   = opn;
    cmd_channels    = ch;
    cmd_mac_mask    = mask;
    cmd_valid       = 1'b1;
  endtask

  task automatic wait_end(input int budget, input string name);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      step();
      hit = (done_q.size() + err_q.size()) > 0;
    end
    chk({name, " end_within_budget"}, int'(hit), 1);
  endtask

  task automatic chk_latched(input string name);
    chk_mask({name, " MAC_enable"}, MAC_enable, last_mask);
    chk({name, " operation"}, int'(operation), int'(last_op));
    chk({name, " kernel_size"}, int'(kernel_size), int'(last_k));
    chk({name, " channels"}, int'(input_channel_size), int'(last_ch));
  endtask

  // Legal command: expected event cycles follow from the row timing 2+L per row,
  // the FIFO-empty history and the psum return delay.
  task automatic run_valid(input logic [31:0] op, input int k, input int pix, input int lat,
                           input int dly, input int mode, input string name);
    logic [MAC_NUM-1:0] mask;
    logic [1:0]  opn;
    logic [11:0] ch;
    int a, cstart, row_len, exp_done;
    mask = rand_mask();
    opn  = 2'($urandom_range(0, 3));
    ch   = 12'($urandom_range(0, 4095));
    clear_rec();
    bram_en = 1'b1; bram_lat = lat; psum_dly = dly; fifo_mode = mode;
    drive_cmd(op, k, pix, opn, ch, mask);
    step();
    // Junk command held while busy must be ignored.
    drive_cmd(32'd87, 5, 16'hAAAA, ~opn, ~ch, ~mask);
    step(); step();
    cmd_valid = 1'b0;
    wait_end(1500, name);
    step(); step();
    last_mask = mask; last_op = opn; last_k = 5'(k); last_ch = ch; last_psum = pix;

    chk({name, " accepts"}, acc_q.size(), 1);
    a = qget(acc_q, 0);
    row_len = 2 + lat;
    chk({name, " err_count"}, err_q.size(), 0);
    chk({name, " done_count"}, done_q.size(), 1);
    if (op == 32'd87) begin
      chk({name, " addr_reset_count"}, ar_q.size(), 1);
      chk({name, " addr_reset_cyc"}, qget(ar_q, 0), a + 1);
      chk({name, " add1_count"}, add1_q.size(), k);
      chk({name, " preload_count"}, pre_q.size(), k);
      for (int i = 0; i < k; i++) begin
        chk($sformatf("%s add1_cyc[%0d]", name, i), qget(add1_q, i), a + 2 + i * row_len);
        chk($sformatf("%s add1_port_sel[%0d]", name, i), qget(add1_ps_q, i), i % 2);
        chk($sformatf("%s preload_cyc[%0d]", name, i), qget(pre_q, i), a + 2 + i * row_len + 1 + lat);
        chk($sformatf("%s preload_port_sel[%0d]", name, i), qget(pre_ps_q, i), i % 2);
      end
      chk({name, " load_weight_count"}, lw_q.size(), 1);
      chk({name, " load_weight_cyc"}, qget(lw_q, 0), a + 2 + k * row_len);
      cstart = a + 3 + k * row_len;
    end else begin
      chk({name, " bram_strobes"}, ar_q.size() + add1_q.size() + pre_q.size() + lw_q.size(), 0);
      cstart = a + 1;
    end
    for (int c = cstart; exp_q.size() < pix && c < cstart + 4000; c++) begin
      if (!emp_hist[c]) exp_q.push_back(32'(c));
    end
    chk({name, " pop_count"}, pop_q.size(), pix);
    for (int i = 0; i < pix; i++) begin
      chk($sformatf("%s pop_cyc[%0d]", name, i), qget(pop_q, i), int'(exp_q[i]));
    end
    chk({name, " pop_while_empty"}, pop_empty, 0);
    chk({name, " psum_count"}, int'(psum_count), pix);
    exp_done = (pix > 0) ? int'(exp_q[pix-1]) + dly + 2 : cstart + 2;
    chk({name, " done_cyc"}, qget(done_q, 0), exp_done);
    chk({name, " ready_after"}, int'(cmd_ready), 1);
    chk_latched(name);
  endtask

  task automatic run_invalid(input logic [31:0] op, input int k, input string name);
    int a;
    clear_rec();
    drive_cmd(op, k, 5, 2'($urandom_range(0, 3)), 12'($urandom_range(0, 4095)), rand_mask());
    step();
    cmd_valid = 1'b0;
    repeat (4) step();
    a = qget(acc_q, 0);
    chk({name, " err_count"}, err_q.size(), 1);
    chk({name, " err_cyc"}, qget(err_q, 0), a + 1);
    chk({name, " busy_cycles"}, busy_cnt, 0);
    chk({name, " done_count"}, done_q.size(), 0);
    chk({name, " psum_count_kept"}, int'(psum_count), last_psum);
    chk_latched(name);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [MAC_NUM-1:0] m;
    logic [1:0]  o;
    logic [11:0] ch;
    int a;
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_opcode = '0; cmd_kernel_size = '0; cmd_channels = '0;
    cmd_pixels = '0; cmd_operation = '0; cmd_mac_mask = '0;
    weight_from_bram_valid = 1'b0; ifmaps_fifo_empty = 1'b0; psum_valid = 1'b0;
    last_mask = '0; last_op = '0; last_k = '0; last_ch = '0; last_psum = 0;
    repeat (3) @(posedge clk);
    #2;
    chk("reset cmd_ready", int'(cmd_ready), 1);
    chk("reset busy", int'(busy), 0);
    chk("reset done_err", int'({done, err}), 0);
    chk("reset strobes", int'({address_reset, bram_control_add1, bram_control_add2, port_sel,
                               load_weight_preload, load_weight, load_ifmaps}), 0);
    chk("reset psum_count", int'(psum_count), 0);
    chk("reset state", int'(dbg_state), 0);
    chk_latched("reset");
    rst_n = 1'b1;
    step();

    run_valid(32'd87, 3, 4, 1, 2, 0, "k3_pix4");
    run_valid(32'd88, 2, 6, 1, 1, 1, "op88_alt_empty");
    run_invalid(32'h55, 3, "bad_opcode");
    run_invalid(32'd87, 0, "k0");
    run_invalid(32'd88, 6, "k6");

    // BRAM never answers: abort after TIMEOUT cycles in W_WAIT.
    clear_rec();
    bram_en = 1'b0; fifo_mode = 0;
    m = rand_mask(); o = 2'd1; ch = 12'd77;
    drive_cmd(32'd87, 2, 4, o, ch, m);
    step();
    cmd_valid = 1'b0;
    wait_end(1200, "bram_timeout");
    step(); step();
    a = qget(acc_q, 0);
    last_mask = m; last_op = o; last_k = 5'd2; last_ch = ch; last_psum = 0;
    chk("bram_timeout err_count", err_q.size(), 1);
    chk("bram_timeout err_cyc", qget(err_q, 0), a + 3 + TIMEOUT);
    chk("bram_timeout add1_count", add1_q.size(), 1);
    chk("bram_timeout preload_count", pre_q.size(), 0);
    chk("bram_timeout load_weight_count", lw_q.size(), 0);
    chk("bram_timeout done_count", done_q.size(), 0);
    chk("bram_timeout busy_after", int'(busy), 0);
    chk_latched("bram_timeout");
    bram_en = 1'b1;

    // Reset in the middle of COMPUTE with 3 pixels still owed.
    clear_rec();
    fifo_mode = 3;
    drive_cmd(32'd88, 2, 3, 2'd2, 12'd5, rand_mask());
    step();
    cmd_valid = 1'b0;
    repeat (3) step();
    fifo_mode = 0;
    step();
    chk("midreset load_ifmaps_before", int'(load_ifmaps), 1);
    chk("midreset busy_before", int'(busy), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("midreset load_ifmaps", int'(load_ifmaps), 0);
    chk("midreset busy", int'(busy), 0);
    chk("midreset done_err", int'({done, err}), 0);
    chk("midreset psum_count", int'(psum_count), 0);
    last_mask = '0; last_op = '0; last_k = '0; last_ch = '0; last_psum = 0;
    chk_latched("midreset");
    step(); step();
    rst_n = 1'b1;
    repeat (6) step();
    chk("midreset cmd_ready_after", int'(cmd_ready), 1);
    chk("midreset no_done", done_q.size(), 0);
    chk("midreset no_err", err_q.size(), 0);

    run_valid(32'd87, 5, 0, 1, 1, 0, "k5_pix0");

    for (int it = 0; it < 8; it++) begin
      run_valid(($urandom_range(0, 1) == 0) ? 32'd87 : 32'd88, int'($urandom_range(1, 5)),
                int'($urandom_range(0, 12)), int'($urandom_range(1, 3)), int'($urandom_range(1, 4)),
                2, $sformatf("rand%0d", it));
    end

    chk("add2_never", add2_cnt, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
